program_counter: RTL and testbench

16-bit SM83 program counter register with a staged incrementer, driven directly by the `pc_*` strobes of the CPU control FSM. It places the PC on the shared address bus for instruction and operand fetches. It accepts three kinds of load: an absolute 16-bit value from the address bus (reset vector), a byte-assembled value from the data bus (jump targets), and a two-phase tap-then-commit increment.

---
 rtl/sm83_pkg.sv | 18 +
 rtl/pc_incrementer.sv | 47 ++++
 rtl/program_counter.sv | 104 ++++++++++
 tb/tb_program_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 address/data widths, reset vector and PC tap state encoding.
package sm83_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   localparam logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(16'h0000);

   typedef enum logic {
      TAP_EMPTY = 1'b0,
      TAP_FULL  = 1'b1
   } tap_state_e;

   function automatic logic [ADDR_W-1:0] pc_plus_one(input logic [ADDR_W-1:0] value);
      return value + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Staged PC incrementer: captures PC+1 into a tap and tracks whether it is still unconsumed.
module pc_incrementer
   import sm83_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_inc_tap_en,
   input  logic              consume,
   input  logic              invalidate,
   output logic [ADDR_W-1:0] tap,
   output logic              pc_tap_valid
);

   tap_state_e state;
   tap_state_e state_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= TAP_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // A capture in the same cycle as a consume/invalidate wins: the new tap is fresh.
   always_comb begin
      state_next = state;
      if (consume || invalidate) begin
         state_next = TAP_EMPTY;
      end
      if (pc_inc_tap_en) begin
         state_next = TAP_FULL;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap <= '0;
      end else if (pc_inc_tap_en) begin
         tap <= pc_plus_one(pc);
      end
   end

   assign pc_tap_valid = (state == TAP_FULL);

endmodule

// File: rtl/program_counter.sv
// SM83 program counter with tristate address-bus driver, byte-assembled loads and a staged increment.
// Define PC_TRACE_EN to expose the registered PC and a count of committed increments.
module program_counter
   import sm83_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [ADDR_W-1:0] addr_bus,
   input  logic [DATA_W-1:0] data_bus,
   input  logic              pc_oe,
   input  logic              pc_wr,
   input  logic              pc_ldh,
   input  logic              pc_ld16,
   input  logic              pc_inc_en,
   input  logic              pc_inc_tap_en,
   output logic              pc_tap_valid,
   output logic              pc_err
`ifdef PC_TRACE_EN
   ,
   output logic [ADDR_W-1:0] pc_q,
   output logic [15:0]       inc_count
`endif
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [DATA_W-1:0] hi_stage;
   logic [ADDR_W-1:0] tap;
   logic              err_next;
   logic              consume;
   logic              invalidate;

   assign addr_bus = pc_oe ? pc : 'z;

   pc_incrementer u_incrementer (
      .clk           (clk),
      .rst           (rst),
      .pc            (pc),
      .pc_inc_tap_en (pc_inc_tap_en),
      .consume       (consume),
      .invalidate    (invalidate),
      .tap           (tap),
      .pc_tap_valid  (pc_tap_valid)
   );

   // Commit source priority: tap increment, then byte-assembled load, then address bus.
   always_comb begin
      pc_next    = pc;
      err_next   = pc_err;
      consume    = 1'b0;
      invalidate = 1'b0;
      if (pc_wr) begin
         if (pc_inc_en) begin
            if (pc_tap_valid) begin
               pc_next = tap;
               consume = 1'b1;
            end else begin
               err_next = 1'b1;
            end
         end else begin
            if (pc_ld16) begin
               pc_next = {hi_stage, data_bus};
            end else begin
               pc_next = addr_bus;
            end
            // A load that actually moves the PC leaves the tap stale.
            invalidate = (pc_next != pc);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc     <= RESET_PC;
         pc_err <= 1'b0;
      end else begin
         pc     <= pc_next;
         pc_err <= err_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_stage <= '0;
      end else if (pc_ldh) begin
         hi_stage <= data_bus;
      end
   end

`ifdef PC_TRACE_EN
   assign pc_q = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inc_count <= '0;
      end else if (consume) begin
         inc_count <= inc_count + 16'(1);
      end
   end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Randomised bench for program_counter against a behavioural PC model, with directed scenarios.
module tb_program_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_bus;
   logic        pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en, pc_inc_tap_en;
   logic [15:0] tb_addr;
   wire  [15:0] addr_bus;
   wire         pc_tap_valid, pc_err;
`ifdef PC_TRACE_EN
   wire  [15:0] pc_q, inc_count;
`endif

   always #5 clk = ~clk;

   // Bench drives the bus whenever the PC does not.
   assign addr_bus = pc_oe ? 16'hzzzz : tb_addr;

   program_counter dut (
      .clk           (clk),
      .rst           (rst),
      .addr_bus      (addr_bus),
      .data_bus      (data_bus),
      .pc_oe         (pc_oe),
      .pc_wr         (pc_wr),
      .pc_ldh        (pc_ldh),
      .pc_ld16       (pc_ld16),
      .pc_inc_en     (pc_inc_en),
      .pc_inc_tap_en (pc_inc_tap_en),
      .pc_tap_valid  (pc_tap_valid),
      .pc_err        (pc_err)
`ifdef PC_TRACE_EN
      ,
      .pc_q          (pc_q),
      .inc_count     (inc_count)
`endif
   );

   // Behavioural model state
   logic [15:0] m_pc, m_tap, m_cnt;
   logic [7:0]  m_hi;
   logic        m_full, m_err;
   int          checks = 0;
   int          failures = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = 16'h0000;
      m_tap  = 16'h0000;
      m_cnt  = 16'h0000;
      m_hi   = 8'h00;
      m_full = 1'b0;
      m_err  = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs held across that edge.
   task automatic model_edge();
      logic [15:0] nxt;
      if (!rst) begin
         model_reset();
         return;
      end
      nxt = m_pc;
      if (pc_wr) begin
         if (pc_inc_en) begin
            if (m_full) begin
               nxt    = m_tap;
               m_full = 1'b0;
               m_cnt  = m_cnt + 16'd1;
            end else begin
               m_err = 1'b1;
            end
         end else begin
            nxt = pc_ld16 ? {m_hi, data_bus} : (pc_oe ? m_pc : tb_addr);
            if (nxt != m_pc) m_full = 1'b0;
         end
      end
      if (pc_inc_tap_en) begin
         m_tap  = m_pc + 16'd1;
         m_full = 1'b1;
      end
      if (pc_ldh) m_hi = data_bus;
      m_pc = nxt;
   endtask

   task automatic set_in(input logic oe, input logic wr, input logic ldh, input logic ld16,
                         input logic inc, input logic tap, input logic [15:0] a, input logic [7:0] d);
      pc_oe = oe; pc_wr = wr; pc_ldh = ldh; pc_ld16 = ld16;
      pc_inc_en = inc; pc_inc_tap_en = tap; tb_addr = a; data_bus = d;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_oe();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic load_pc(input logic [15:0] v);
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v, 8'h00);
      tick();
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      model_reset();
      tick();
      rst = 1'b1;
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("addr_bus", 32'(addr_bus), 32'(pc_oe ? m_pc : tb_addr));
         check("pc_tap_valid", 32'(pc_tap_valid), 32'(m_full));
         check("pc_err", 32'(pc_err), 32'(m_err));
`ifdef PC_TRACE_EN
         check("pc_q", 32'(pc_q), 32'(m_pc));
         check("inc_count", 32'(inc_count), 32'(m_cnt));
`endif
      end
   end

   initial begin
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00);
      model_reset();
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("reset_valid", 32'(pc_tap_valid), 32'h0);
      check("reset_err", 32'(pc_err), 32'h0);
      check("reset_released", 32'(addr_bus), 32'h1234);

      // Absolute load from the address bus
      load_pc(16'h0150);
      idle_oe(); #1;
      check("load_0150", 32'(addr_bus), 32'h0150);
      tick();

      // Tap then commit
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0); #1;
      check("tap_valid_high", 32'(pc_tap_valid), 32'h1);
      check("pc_before_commit", 32'(addr_bus), 32'h0150);
      tick();
      idle_oe(); #1;
      check("inc_0151", 32'(addr_bus), 32'h0151);
      check("tap_valid_low", 32'(pc_tap_valid), 32'h0);
      check("no_err_after_inc", 32'(pc_err), 32'h0);
      tick();

      // Held commit after a single tap increments once and flags an error
      load_pc(16'h0150);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
      tick();
      tick();
      idle_oe(); #1;
      check("double_inc_pc", 32'(addr_bus), 32'h0151);
      check("double_inc_err", 32'(pc_err), 32'h1);
      tick();

      // Byte-assembled load, plus ldh/ld16 coincident using the old high byte
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'hC3);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h21);
      tick();
      idle_oe(); #1;
      check("ld16_c321", 32'(addr_bus), 32'hC321);
      tick();
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h55);
      tick();
      idle_oe(); #1;
      check("ldh_ld16_old_hi", 32'(addr_bus), 32'hC355);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h66);
      tick();
      idle_oe(); #1;
      check("ld16_new_hi", 32'(addr_bus), 32'h5566);
      tick();

      // Wrap from FFFF
      pulse_reset();
      load_pc(16'hFFFF);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
      tick();
      idle_oe(); #1;
      check("wrap_pc", 32'(addr_bus), 32'h0000);
      check("wrap_err", 32'(pc_err), 32'h0);
      tick();

      // Reset mid-sequence with tap full and error set
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
      tick();
      load_pc(16'h4000);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD, 8'h0); #1;
      check("pre_rst_valid", 32'(pc_tap_valid), 32'h1);
      check("pre_rst_err", 32'(pc_err), 32'h1);
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_valid", 32'(pc_tap_valid), 32'h0);
      check("rst_err", 32'(pc_err), 32'h0);
      check("rst_bus_released", 32'(addr_bus), 32'hABCD);
      pc_oe = 1'b1; #1;
      check("rst_pc", 32'(addr_bus), 32'h0000);
      tick();
      rst = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
      tick();
      idle_oe(); #1;
      check("lost_increment", 32'(addr_bus), 32'h0000);
      tick();

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] a;
         a = ($urandom % 4 == 0) ? (16'hFFFE + 16'($urandom % 2)) : 16'($urandom);
         set_in(1'($urandom % 2), ($urandom % 100) < 40, ($urandom % 100) < 20,
                ($urandom % 100) < 25, ($urandom % 100) < 40, ($urandom % 100) < 35,
                a, 8'($urandom));
         if ($urandom % 400 == 0) begin
            rst = 1'b0;
            model_reset();
            tick();
            rst = 1'b1;
         end else begin
            tick();
         end
      end

      idle_oe();
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
